// File: rtl/ropuf_eval_ctrl.sv
// RO-PUF evaluation sequencer: drives chal/enable/reset for VOTES rounds and
// returns a per-bit majority response plus a mask of bits that disagreed.
module ropuf_eval_ctrl #(
  parameter int unsigned WIDTH         = 22,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned EVAL_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned VOTES         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_chal,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] rsp_unstable,
  output logic             busy,
  output logic [WIDTH-1:0] puf_chal,
  output logic             puf_enable,
  output logic             puf_reset,
  input  logic [WIDTH-1:0] puf_resp
);

  localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned EVAL_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CNT_A  = (RST_W > EVAL_W) ? RST_W : EVAL_W;
  localparam int unsigned CNT_W  = (CNT_A > SET_W) ? CNT_A : SET_W;
  localparam int unsigned RND_W  = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int unsigned ONES_W = $clog2(VOTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_EVAL, S_SETTLE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RND_W-1:0]   r_round, w_round_nxt;
  logic [ONES_W-1:0]  r_ones [WIDTH];
  logic [ONES_W-1:0]  w_ones_nxt [WIDTH];
  logic [WIDTH-1:0]   r_chal, w_chal_nxt;
  logic               r_enable, w_enable_nxt;
  logic               r_preset, w_preset_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic [WIDTH-1:0]   r_rsp_unst, w_rsp_unst_nxt;
  logic               r_busy;
  logic               w_req_ready;

  assign w_req_ready  = (r_state == S_IDLE) && !abort;
  assign req_ready    = w_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_unstable = r_rsp_unst;
  assign busy         = r_busy;
  assign puf_chal     = r_chal;
  assign puf_enable   = r_enable;
  assign puf_reset    = r_preset;

  // Next-state and next-output logic; pin outputs are registered from these.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_round_nxt     = r_round;
    w_ones_nxt      = r_ones;
    w_chal_nxt      = r_chal;
    w_enable_nxt    = 1'b0;
    w_preset_nxt    = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_unst_nxt  = r_rsp_unst;
    case (r_state)
      S_IDLE: begin
        if (req_valid && w_req_ready) begin
          w_state_nxt  = S_RST;
          w_cnt_nxt    = CNT_W'(RST_CYCLES - 1);
          w_round_nxt  = '0;
          w_chal_nxt   = req_chal;
          w_preset_nxt = 1'b1;
          for (int i = 0; i < WIDTH; i++) w_ones_nxt[i] = '0;
        end
      end
      S_RST: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_EVAL;
          w_cnt_nxt    = CNT_W'(EVAL_CYCLES - 1);
          w_enable_nxt = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_preset_nxt = 1'b1;
        end
      end
      S_EVAL: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_enable_nxt = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          for (int i = 0; i < WIDTH; i++) w_ones_nxt[i] = r_ones[i] + ONES_W'(puf_resp[i]);
          if (r_round == RND_W'(VOTES - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt  = S_RST;
            w_round_nxt  = r_round + RND_W'(1);
            w_cnt_nxt    = CNT_W'(RST_CYCLES - 1);
            w_preset_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_rsp_valid_nxt = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          w_rsp_data_nxt[i] = r_ones[i] > ONES_W'(VOTES / 2);
          w_rsp_unst_nxt[i] = (r_ones[i] != '0) && (r_ones[i] != ONES_W'(VOTES));
        end
        if (r_rsp_valid && rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_chal_nxt      = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort discards the request from any active state, including DONE.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_enable_nxt    = 1'b0;
      w_preset_nxt    = 1'b0;
      w_rsp_valid_nxt = 1'b0;
      w_chal_nxt      = '0;
      for (int i = 0; i < WIDTH; i++) w_ones_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_round     <= '0;
      r_chal      <= '0;
      r_enable    <= 1'b0;
      r_preset    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_unst  <= '0;
      r_busy      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) r_ones[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_round     <= w_round_nxt;
      r_chal      <= w_chal_nxt;
      r_enable    <= w_enable_nxt;
      r_preset    <= w_preset_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_unst  <= w_rsp_unst_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      for (int i = 0; i < WIDTH; i++) r_ones[i] <= w_ones_nxt[i];
    end
  end

endmodule

// File: tb/tb_ropuf_eval_ctrl.sv
// Scoreboard bench for ropuf_eval_ctrl with a table-driven PUF array model,
// plus a single-vote instance.
module tb_ropuf_eval_ctrl;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] unst;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, abort, rsp_valid, rsp_ready, busy;
  logic [3:0] req_chal, rsp_data, rsp_unstable, puf_chal, puf_resp;
  logic       puf_enable, puf_reset;

  logic       req_valid1, req_ready1, rsp_valid1, busy1, puf_enable1, puf_reset1;
  logic [3:0] req_chal1, rsp_data1, rsp_unstable1, puf_chal1, puf_resp1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [3:0] tbl [4];
  int         base = 0;
  int         nrise = 0;
  int         ridx;
  logic       prev_rst = 1'b0;

  always #5 clk = ~clk;

  ropuf_eval_ctrl #(.WIDTH(4), .RST_CYCLES(2), .EVAL_CYCLES(8), .SETTLE_CYCLES(1), .VOTES(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_chal(req_chal),
    .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unstable(rsp_unstable), .busy(busy), .puf_chal(puf_chal), .puf_enable(puf_enable),
    .puf_reset(puf_reset), .puf_resp(puf_resp));

  ropuf_eval_ctrl #(.WIDTH(4), .RST_CYCLES(2), .EVAL_CYCLES(8), .SETTLE_CYCLES(1), .VOTES(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .req_chal(req_chal1),
    .abort(1'b0), .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_data(rsp_data1),
    .rsp_unstable(rsp_unstable1), .busy(busy1), .puf_chal(puf_chal1), .puf_enable(puf_enable1),
    .puf_reset(puf_reset1), .puf_resp(puf_resp1));

  // Array model: each rising puf_reset starts a new round and selects the next table entry.
  always @(posedge clk) begin
    if (puf_reset && !prev_rst) nrise <= nrise + 1;
    prev_rst <= puf_reset;
  end

  always_comb begin
    ridx = nrise - base - 1;
    if (ridx < 0) ridx = 0;
    if (ridx > 3) ridx = 3;
    puf_resp = tbl[ridx];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every response handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset && rsp_valid && sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else if (reset && rsp_valid && rsp_ready) begin
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_unstable", 32'(rsp_unstable), 32'(e.unst));
      end
    end
  end

  // Issue one request from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] chal);
    req_valid = 1'b1;
    req_chal  = chal;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int c;
    c = 0;
    while (!rsp_valid && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic quiet(input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    check("no_response", 32'(hits), 32'd0);
  endtask

  initial begin
    int errs;
    int c;
    reset = 1'b0; req_valid = 1'b0; req_chal = '0; abort = 1'b0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_chal1 = '0; puf_resp1 = '0;
    tbl = '{4'h0, 4'h0, 4'h0, 4'h0};
    #3;
    check("reset_outs", 32'({puf_chal, puf_enable, puf_reset, rsp_valid, busy, rsp_data, rsp_unstable}), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Constant 5 response, plus waveform and latency check
    tbl = '{4'h5, 4'h5, 4'h5, 4'h0};
    base = nrise;
    sb.push_back('{data: 4'h5, unst: 4'h0});
    send(4'hA);
    errs = 0;
    for (c = 0; c < 34; c++) begin
      if (puf_reset  !== (c < 33 && (c % 11) < 2)) errs++;
      if (puf_enable !== (c < 33 && (c % 11) >= 2 && (c % 11) < 10)) errs++;
      if (puf_chal !== 4'hA || busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    check("waveform", 32'(errs), 32'd0);
    check("latency_34", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs", 32'({rsp_valid, busy, puf_chal}), 32'd0);

    // Mixed votes with backpressure; held request accepted right after the handshake
    tbl = '{4'h3, 4'h5, 4'h6, 4'h0};
    base = nrise;
    sb.push_back('{data: 4'h7, unst: 4'h7});
    send(4'h6);
    wait_valid(60);
    req_valid = 1'b1;
    req_chal  = 4'h9;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h7 || rsp_unstable !== 4'h7) errs++;
      if (req_ready !== 1'b0 || puf_chal !== 4'h6) errs++;
      @(negedge clk);
    end
    check("hold_stable", 32'(errs), 32'd0);
    tbl = '{4'hF, 4'hF, 4'hF, 4'h0};
    sb.push_back('{data: 4'hF, unst: 4'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    base = nrise;
    check("idle_after_hs", 32'({req_ready, busy, rsp_valid}), 32'b100);
    @(negedge clk);
    req_valid = 1'b0;
    check("second_accept", 32'({busy, req_ready, puf_chal}), 32'({1'b1, 1'b0, 4'h9}));
    wait_valid(60);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Abort during round-2 EVAL, then a clean request
    tbl = '{4'h1, 4'h1, 4'h1, 4'h0};
    base = nrise;
    send(4'hC);
    repeat (15) @(negedge clk);
    check("in_eval_r2", 32'(puf_enable), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_outs", 32'({puf_enable, puf_reset, rsp_valid, busy, puf_chal}), 32'd0);
    check("abort_idle_rdy", 32'(req_ready), 32'd0);
    abort = 1'b0;
    #1;
    check("idle_rdy", 32'(req_ready), 32'd1);
    quiet(40);
    @(negedge clk);
    tbl = '{4'h3, 4'h3, 4'h3, 4'h0};
    base = nrise;
    sb.push_back('{data: 4'h3, unst: 4'h0});
    rsp_ready = 1'b1;
    send(4'h3);
    wait_valid(60);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Asynchronous reset mid-EVAL
    base = nrise;
    send(4'h5);
    repeat (5) @(negedge clk);
    check("pre_reset_eval", 32'(puf_enable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'({puf_chal, puf_enable, puf_reset, rsp_valid, busy, rsp_data, rsp_unstable}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset", 32'({req_ready, busy}), 32'b10);
    quiet(40);

    // Single-vote instance: never unstable
    for (int t = 0; t < 2; t++) begin
      puf_resp1 = (t == 0) ? 4'hB : 4'h6;
      @(negedge clk);
      req_valid1 = 1'b1;
      req_chal1  = 4'h2;
      @(negedge clk);
      req_valid1 = 1'b0;
      c = 0;
      while (!rsp_valid1 && c < 40) begin
        @(negedge clk);
        c++;
      end
      check("v1_latency", 32'(c), 32'd12);
      check("v1_data", 32'(rsp_data1), 32'((t == 0) ? 4'hB : 4'h6));
      check("v1_unstable", 32'(rsp_unstable1), 32'd0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
